// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative encryption core:
//   NR_AES128 - number of rounds supported by the core
//   block_t   - 128-bit AES state / round key
//   state_t   - control FSM encoding (IDLE, ROUND, DONE)
//   RCON      - key-schedule round constants, RCON[i] used for round i+1
//   SBOX      - forward AES S-box, shared by SubBytes and the key schedule
//   sbox()    - S-box lookup
//   xtime()   - multiply-by-x in GF(2^8) with the AES polynomial
//   rcon_at() - range-safe RCON lookup
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Outside ROUND the round counter can sit at 0, which would index RCON[-1];
    // return 0 there instead so the key-step input stays defined.
    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// ---------------------------------------------------------------------------
// aes128_iter_core_if
// Block-level handshake bundle for the iterative AES-128 core.
//   in_valid / in_ready / in_data  : {key[255:128], msg[127:0]} input stream
//   out_valid / out_ready / out_data: 128-bit ciphertext output stream
// Modports:
//   master - producer/consumer side (drives in_*, out_ready)
//   slave  - the core (drives in_ready, out_valid, out_data)
// ---------------------------------------------------------------------------
interface aes128_iter_core_if;

    logic           in_valid;
    logic           in_ready;
    logic [255:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    aes_pkg::block_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/add_round_key.sv
// ---------------------------------------------------------------------------
// add_round_key
// AES AddRoundKey: bitwise XOR of the state with a round key.
//   din  - 128-bit state in
//   key  - 128-bit round key
//   dout - 128-bit state out
// ---------------------------------------------------------------------------
module add_round_key
    import aes_pkg::*;
(
    input  block_t din,
    input  block_t key,
    output block_t dout
);

    assign dout = din ^ key;

endmodule

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-schedule step, combinational. Splits the key into words
// w0..w3 (w0 = key[127:96]) and produces the next round key.
//   key      - current round key
//   rcon     - round constant for this step
//   next_key - following round key
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  block_t     key,
    input  logic [7:0] rcon,
    output block_t     next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h0};

    // Each new word chains off the one just produced, not the old one.
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// ---------------------------------------------------------------------------
// mix_columns
// AES MixColumns: each 4-byte column is multiplied by the fixed circulant
// matrix {02 03 01 01} over GF(2^8).
//   din  - 128-bit state in
//   dout - 128-bit state out
// ---------------------------------------------------------------------------
module mix_columns
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];

        // 3*x is xtime(x) ^ x
        assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/shift_rows.sv
// ---------------------------------------------------------------------------
// shift_rows
// AES ShiftRows on a column-major state: byte k sits at row k%4, column k/4,
// byte 0 in bits [127:120]. Row r is rotated left by r positions.
//   din  - 128-bit state in
//   dout - 128-bit state out
// ---------------------------------------------------------------------------
module shift_rows
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// ---------------------------------------------------------------------------
// sub_bytes
// AES SubBytes: applies the S-box to each of the 16 state bytes.
//   din  - 128-bit state in
//   dout - 128-bit state out
// ---------------------------------------------------------------------------
module sub_bytes
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_iter_core.sv
// ---------------------------------------------------------------------------
// aes128_iter_core
// Iterative AES-128 encryption engine: one round per clock, a full
// 10-round encryption per accepted {key, msg} block. Accept at edge T,
// ciphertext valid after edge T+10, one block per 11 cycles back-to-back.
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bus   - slave side of the in/out valid-ready handshake
//   busy  - high while rounds are executing
//   round - current round index 0..10 (debug)
// ---------------------------------------------------------------------------
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic                      clk,
    input  logic                      rst,
    aes128_iter_core_if.slave         bus,
    output logic                      busy,
    output logic [3:0]                round
);

    if (NR != NR_AES128) begin : g_nr_check
        $error("aes128_iter_core only supports NR = 10 (AES-128)");
    end

    localparam logic [3:0] LAST = 4'(NR);

    state_t     fsm_q, fsm_d;
    block_t     state_q, state_d;
    block_t     key_q, key_d;
    logic [3:0] round_q, round_d;

    block_t     in_key, in_msg, init_state;
    block_t     next_key, sb_out, sr_out, mc_out, pre_ark, round_out;
    logic [7:0] rcon;
    logic       accept, last_round;

    assign in_key = bus.in_data[255:128];
    assign in_msg = bus.in_data[127:0];

    // ---------------- datapath ----------------
    add_round_key u_ark_init (.din(in_msg), .key(in_key), .dout(init_state));

    assign rcon = rcon_at(round_q - 4'd1);

    aes_key_step  u_key_step (.key(key_q), .rcon(rcon), .next_key(next_key));

    sub_bytes     u_sub   (.din(state_q), .dout(sb_out));
    shift_rows    u_shift (.din(sb_out),  .dout(sr_out));
    mix_columns   u_mix   (.din(sr_out),  .dout(mc_out));

    assign last_round = (round_q == LAST);

    // The final round skips MixColumns.
    assign pre_ark = last_round ? sr_out : mc_out;

    add_round_key u_ark_round (.din(pre_ark), .key(next_key), .dout(round_out));

    // ---------------- handshake ----------------
    assign bus.in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_data  = state_q;
    assign accept        = bus.in_valid && bus.in_ready;

    assign busy  = (fsm_q == ROUND);
    assign round = round_q;

    // ---------------- control ----------------
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;

        case (fsm_q)
            IDLE, DONE: begin
                if (accept) begin
                    // DONE with out_ready and in_valid chains straight into
                    // the next block with no idle cycle.
                    state_d = init_state;
                    key_d   = in_key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end else if ((fsm_q == DONE) && bus.out_ready) begin
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end
            end

            ROUND: begin
                state_d = round_out;
                key_d   = next_key;
                if (last_round) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine.
- Wraps the existing single-round datapath modules (SubBytes, ShiftRows, MixColumns, AddRoundKey) with a state register, a run-time round-key register and a round counter.
- Runs one round per clock, giving a full 10-round encryption per accepted {key, msg} block.
- Sits directly upstream of the combinational round stage: it sequences that stage at run time instead of using compile-time round indices, and presents the ciphertext on a valid/ready output.

Parameters:
- NR, 10, number of AES rounds. Only 10 (AES-128) is supported; elaboration fails on any other value.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input block offered.
- in_ready  output  1  core can accept a block this cycle.
- in_data  input  256  {key[255:128], msg[127:0]}. Byte 0 of each half is bits [127:120] (FIPS-197 order).
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer takes ciphertext this cycle.
- out_data  output  128  ciphertext.
- busy  output  1  high while rounds are executing (state ROUND).
- round  output  4  current round index, 0..10 (debug).

Behaviour:
- Reset (rst=0, async) forces the following, regardless of any operation in flight:
  - FSM to IDLE.
  - state_q, key_q and out_data to 128'h0.
  - round to 0.
  - out_valid, busy to 0.
  - in_ready to 1 once rst deasserts.
- FSM has three states: IDLE, ROUND, DONE.
- in_ready = (IDLE) or (DONE and out_ready).
- Accept occurs when in_valid && in_ready. On accept:
  - state_q <= msg ^ key (initial AddRoundKey).
  - key_q <= key.
  - round <= 1.
  - FSM goes to ROUND.
- ROUND, each cycle:
  - next_key = key_expand(key_q, RCON[round-1]).
  - If round < NR: state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ next_key.
  - If round == NR: state_q <= ShiftRows(SubBytes(state_q)) ^ next_key (no MixColumns); FSM goes to DONE.
  - key_q <= next_key; round <= round + 1, saturating at NR.
- DONE:
  - out_valid = 1 and out_data = state_q, held stable until out_ready.
  - If out_ready and in_valid in the same cycle: the new block is accepted and the FSM goes straight to ROUND (back-to-back, no bubble).
  - If out_ready without in_valid: FSM goes to IDLE, round <= 0, out_valid drops next cycle.
- Latency is 11 cycles: accept at edge T, out_valid high after edge T+10. Throughput is 1 block per 11 cycles under back-to-back operation.
- in_data is sampled only at accept. Changes to in_data during ROUND or DONE have no effect.
- in_valid asserted during ROUND is ignored, because in_ready=0. The producer holds in_valid until accepted.
- out_valid never deasserts without out_ready, except on reset.
- key_expand (one AES-128 key-schedule step) operates on 32-bit words w0..w3 of key_q, with w0 = key_q[127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.

Decomposition:
- Package aes_pkg holds:
  - NR_AES128 = 10.
  - RCON[0:9] = 01,02,04,08,10,20,40,80,1b,36.
  - FSM enum state_t {IDLE, ROUND, DONE}.
  - Typedef block_t = logic [127:0].
- One new sub-module: aes_key_step, inputs key[127:0] and rcon[7:0], output next_key[127:0], combinational. It reuses the codebase S-box from SubBytes.
- Round datapath reuses SubBytes, ShiftRows, MixColumns and AddRoundKey unchanged.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, msg 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after the accept edge.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; round steps 1..10.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable, out_valid held, in_ready=0. Then out_ready=1 with no in_valid -> IDLE next cycle, in_ready=1.
- Back-to-back: App. B block then C.1 block with out_ready=1 and in_valid held high -> second accept in the same cycle as the first output handshake; second result 11 cycles later; both ciphertexts correct.
- Reset mid-operation: assert rst=0 at round 5 -> out_valid=0, busy=0, round=0 and out_data=0 immediately (asynchronous). After release, C.1 vector encrypts correctly.
- Ignore while busy: pulse in_valid with a different block during ROUND -> no accept, result equals the original block's ciphertext.
